// File: rtl/serial_data_port_pkg.sv
// rtl/serial_data_port_pkg.sv - shared state encoding and beat-count helpers for serial_data_port
package serial_data_port_pkg;

  typedef enum logic [1:0] {
    SDP_IDLE  = 2'd0,
    SDP_SHIFT = 2'd1,
    SDP_DONE  = 2'd2
  } sdp_state_t;

  function automatic int beats_per_reg(input int reg_bits, input int nshift);
    return reg_bits / nshift;
  endfunction

endpackage

// File: rtl/serial_data_port.sv
// rtl/serial_data_port.sv - parallel/serial adapter feeding and collecting the 2-bit serial ALU
module serial_data_port
  import serial_data_port_pkg::*;
#(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [2*REG_BITS-1:0]                    in_data,
  input  logic                                     in_pair,
  input  logic                                     stall,
  output logic                                     advance,
  output logic [NSHIFT-1:0]                        ser_out,
  input  logic [NSHIFT-1:0]                        ser_in,
  output logic [$clog2(2*REG_BITS/NSHIFT)-1:0]     beat,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [2*REG_BITS-1:0]                    out_data
);

  localparam int W            = 2 * REG_BITS;
  localparam int BEATS_SINGLE = beats_per_reg(REG_BITS, NSHIFT);
  localparam int BW           = $clog2(2 * BEATS_SINGLE);
  localparam logic [BW-1:0] LAST_PAIR   = BW'(2 * BEATS_SINGLE - 1);
  localparam logic [BW-1:0] LAST_SINGLE = BW'(BEATS_SINGLE - 1);

  sdp_state_t     state, state_next;
  logic [W-1:0]   sr;
  logic           pair;
  logic           load;
  logic           last;

  assign ser_out = sr[NSHIFT-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SDP_IDLE;
      sr    <= '0;
      beat  <= '0;
      pair  <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        sr   <= in_data;
        pair <= in_pair;
        beat <= '0;
      end else if (advance) begin
        // result bits enter at the top while operand bits leave at the bottom
        sr   <= {ser_in, sr[W-1:NSHIFT]};
        beat <= last ? '0 : beat + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    advance    = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    load       = 1'b0;
    last       = (beat == (pair ? LAST_PAIR : LAST_SINGLE));
    case (state)
      SDP_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = SDP_SHIFT;
        end
      end
      SDP_SHIFT: begin
        advance = !stall;
        if (advance && last) state_next = SDP_DONE;
      end
      SDP_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // a single-width result has only been shifted into the upper half
        out_data  = pair ? sr : {{REG_BITS{1'b0}}, sr[W-1:REG_BITS]};
        if (out_ready) begin
          if (in_valid) begin
            load       = 1'b1;
            state_next = SDP_SHIFT;
          end else begin
            state_next = SDP_IDLE;
          end
        end
      end
      default: state_next = SDP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_data_port.sv
// tb/tb_serial_data_port.sv - randomized self-checking bench for serial_data_port
module tb_serial_data_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_pair = 1'b0;
  logic        stall = 1'b0;
  logic        advance;
  logic [1:0]  ser_out;
  logic [1:0]  ser_in;
  logic [2:0]  beat;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  bit          alu_inc = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // ALU stand-in: identity or +1 per bit pair, combinational from ser_out
  assign ser_in = alu_inc ? ser_out + 2'd1 : ser_out;

  serial_data_port #(.REG_BITS(8), .NSHIFT(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_pair(in_pair), .stall(stall), .advance(advance),
    .ser_out(ser_out), .ser_in(ser_in), .beat(beat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  function automatic logic [15:0] model(input logic [15:0] d, input bit pr, input bit inc);
    logic [15:0] r = '0;
    int n = pr ? 8 : 4;
    for (int k = 0; k < n; k++) begin
      logic [1:0] p = 2'((d >> (2 * k)) & 16'd3);
      if (inc) p = p + 2'd1;
      r = r | (16'(p) << (2 * k));
    end
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full operation, starting at the accept cycle (start of cycle, inputs not yet sampled)
  task automatic run_op(input logic [15:0] d, input bit pr, input bit inc, input bit rnd_stall,
                        input int lo, input int hi, input int hold, input bit chain,
                        input logic [15:0] nd, input bit np, input string name);
    int n = pr ? 8 : 4;
    int c = 0;
    int beats = 0;
    int nstall = 0;
    logic [15:0] exp = model(d, pr, inc);
    alu_inc = inc;
    in_valid = 1'b1; in_data = d; in_pair = pr; stall = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || advance !== 1'b0) begin
      errors++; $display("FAIL %s accept: in_ready=%b advance=%b, want 1/0", name, in_ready, advance);
    end
    while (beats < n && c < 100) begin
      cyc(); c++;
      in_valid = 1'b0; in_data = 16'($urandom); in_pair = 1'($urandom); out_ready = 1'($urandom);
      stall = rnd_stall ? ($urandom_range(0, 2) == 0) : (c >= lo && c <= hi);
      @(negedge clk);
      checks++; if (advance !== !stall || out_valid !== 1'b0) begin
        errors++; $display("FAIL %s cyc%0d advance=%b out_valid=%b, want %b/0", name, c, advance, out_valid, !stall);
      end
      if (!stall) begin
        checks++; if (beat !== 3'(beats) || ser_out !== 2'((d >> (2 * beats)) & 16'd3)) begin
          errors++; $display("FAIL %s beat%0d beat=%0d ser_out=%0d", name, beats, beat, ser_out);
        end
        beats++;
      end else begin
        nstall++;
        checks++; if (beat !== 3'(beats)) begin
          errors++; $display("FAIL %s stall cyc%0d beat=%0d, want %0d", name, c, beat, beats);
        end
      end
    end
    cyc(); c++;
    out_ready = 1'b0; stall = 1'($urandom);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || c !== n + 1 + nstall || out_data !== exp || advance !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL %s result cyc%0d out_valid=%b out_data=%h advance=%b in_ready=%b, want cyc%0d 1 %h 0 0",
                         name, c, out_valid, out_data, advance, in_ready, n + 1 + nstall, exp);
    end
    for (int h = 0; h < hold; h++) begin
      cyc(); stall = 1'($urandom); in_valid = 1'($urandom);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0 || advance !== 1'b0) begin
        errors++; $display("FAIL %s hold%0d out_valid=%b out_data=%h in_ready=%b, want 1 %h 0", name, h, out_valid, out_data, in_ready, exp);
      end
    end
    cyc();
    out_ready = 1'b1; stall = 1'b0;
    if (chain) begin
      in_valid = 1'b1; in_data = nd; in_pair = np;
    end else begin
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++; $display("FAIL %s release in_ready=%b out_valid=%b, want 1/1", name, in_ready, out_valid);
      end
      cyc(); out_ready = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || advance !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL %s idle out_valid=%b advance=%b in_ready=%b, want 0 0 1", name, out_valid, advance, in_ready);
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || advance !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || ser_out !== 2'b0 || beat !== 3'd0) begin
      errors++; $display("FAIL reset in_ready=%b advance=%b out_valid=%b out_data=%h ser_out=%b beat=%0d", in_ready, advance, out_valid, out_data, ser_out, beat);
    end
    cyc();
  endtask

  task automatic test_loopback();
    run_op(16'hA5C3, 1'b1, 1'b0, 1'b0, 0, -1, 0, 1'b0, 16'h0, 1'b0, "loop_pair");
    run_op(16'h12B7, 1'b0, 1'b0, 1'b0, 0, -1, 0, 1'b0, 16'h0, 1'b0, "loop_single");
  endtask

  task automatic test_stall();
    run_op(16'hA5C3, 1'b1, 1'b0, 1'b0, 3, 5, 0, 1'b0, 16'h0, 1'b0, "stall_pair");
  endtask

  task automatic test_back_to_back();
    run_op(16'hA5C3, 1'b1, 1'b0, 1'b0, 0, -1, 5, 1'b1, 16'h0001, 1'b1, "hold");
    run_op(16'h0001, 1'b1, 1'b0, 1'b0, 0, -1, 0, 1'b0, 16'h0, 1'b0, "chained");
  endtask

  task automatic test_alu_increment();
    run_op(16'h0000, 1'b1, 1'b1, 1'b0, 0, -1, 0, 1'b0, 16'h0, 1'b0, "alu_inc");
    checks++; if (model(16'h0000, 1'b1, 1'b1) !== 16'h5555) begin
      errors++; $display("FAIL alu_model got=%h want 5555", model(16'h0000, 1'b1, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    alu_inc = 1'b0;
    in_valid = 1'b1; in_data = 16'hBEEF; in_pair = 1'b1; stall = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(); in_valid = 1'b0;
    end
    @(negedge clk);
    checks++; if (beat !== 3'd4 || advance !== 1'b1) begin
      errors++; $display("FAIL reset_mid pre beat=%0d advance=%b, want 4/1", beat, advance);
    end
    reset = 1'b1;
    cyc(); reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || advance !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || ser_out !== 2'b0 || beat !== 3'd0) begin
      errors++; $display("FAIL reset_mid post in_ready=%b advance=%b out_valid=%b out_data=%h ser_out=%b beat=%0d", in_ready, advance, out_valid, out_data, ser_out, beat);
    end
    for (int c = 0; c < 12; c++) begin
      cyc(); @(negedge clk);
      if (out_valid !== 1'b0 || advance !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL reset_mid aftermath active_cycles=%0d, want 0", seen);
    end
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [15:0] d, nd;
    bit p, np, ch;
    nd = 16'($urandom); np = 1'($urandom);
    for (int i = 0; i < 24; i++) begin
      d = nd; p = np;
      nd = 16'($urandom); np = 1'($urandom);
      ch = (i < 23) && ($urandom_range(0, 1) == 1);
      run_op(d, p, 1'($urandom), 1'b1, 0, -1, $urandom_range(0, 3), ch, nd, np, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stall();
    test_back_to_back();
    test_alu_increment();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_data_port.md
# serial_data_port

Parallel-to-serial and serial-to-parallel adapter between the byte/word-wide memory side and the 2-bit-per-cycle serial ALU datapath. It accepts a 16-bit operand with a valid/ready handshake and streams it LSB first into the ALU's serial data input. In the same cycles it captures the ALU's serial result output and presents the reassembled result word with a valid/ready handshake. It owns the beat count and drives the ALU `advance` strobe, so the ALU and this block always agree on which bit pair is in flight.

## Interface
Parameters:
- `REG_BITS`, 8, bits per register/byte.
- `NSHIFT`, 2, bits transferred per beat; `REG_BITS` must be divisible by `NSHIFT`.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: operand available.
- `in_ready` out 1: operand accepted when `in_valid && in_ready`.
- `in_data` in 2*REG_BITS: operand, LSB streamed first.
- `in_pair` in 1: 1 selects 16-bit op (8 beats), 0 selects 8-bit op (4 beats); sampled at accept.
- `stall` in 1: freezes beat progress while high.
- `advance` out 1: ALU shift strobe; high exactly on beat cycles.
- `ser_out` out NSHIFT: to ALU `data_in2`.
- `ser_in` in NSHIFT: from ALU `data_out`; sampled on beat cycles.
- `beat` out log2(2*REG_BITS/NSHIFT): current beat index, equal to the ALU counter.
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_data` out 2*REG_BITS: result word, right-aligned, zero-filled above bit 7 for 8-bit ops.

## Operation
- One shift register `sr[2*REG_BITS-1:0]` holds both the operand and the result.
  - `ser_out = sr[NSHIFT-1:0]`.
  - Each beat: `sr <= {ser_in, sr[2*REG_BITS-1:NSHIFT]}`.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: `in_ready=1`. On accept, load `sr<=in_data`, latch `pair<=in_pair`, set `beat<=0`, go to SHIFT.
  - SHIFT: `advance = !stall`. Each advance cycle increments `beat`. When `beat` reaches last (7 for pair, 3 for single) and advance is high, go to DONE and reset `beat` to 0.
  - DONE: `out_valid=1`, `out_data = pair ? sr : {0, sr[2*REG_BITS-1:REG_BITS]}`.
    - On `out_ready`: if `in_valid` in the same cycle, accept the new operand and go straight to SHIFT. Otherwise go to IDLE.
    - `in_ready = out_ready` in DONE.
- `stall` is ignored outside SHIFT.
- `out_data` and `out_valid` are stable while `out_ready=0`.
- Reset mid-operation abandons the transfer; no `out_valid` is generated for it.

## Timing
- Reset values: state IDLE, `sr=0`, `beat=0`, `pair=0`, `in_ready=1`, `advance=0`, `out_valid=0`, `out_data=0`, `ser_out=0`.
- Accept at cycle 0. Beats occur at cycles 1..N, with N=8 for pair and N=4 for single, plus one extra cycle per stalled cycle. `out_valid` rises on cycle N+1.
- `ser_in` is sampled in the same cycle that the corresponding `ser_out` is driven; the ALU path is combinational.
- Back-to-back throughput is one operation per N+1 cycles.
- `advance` is purely a function of the registered state and `stall`; it has no combinational path from `in_valid`.

## Structure
- Shared package/header `common.vh`: `SDP_IDLE`, `SDP_SHIFT`, `SDP_DONE` state encodings, and beat-count constants derived from `REG_BITS/NSHIFT`.
- No sub-module. A single shift register and FSM is sufficient; the ALU is connected at the top level.

## Test plan
- Loopback (`ser_in=ser_out`), pair, `in_data=16'hA5C3`, accepted at cycle 0 -> `advance` high cycles 1-8, `beat` 0..7, `out_valid` at cycle 9, `out_data=16'hA5C3`.
- Loopback, single, `in_data=16'h12B7` -> 4 beats, `out_valid` at cycle 5, `out_data=16'h00B7`.
- Pair with `stall` high cycles 3-5 -> `advance` low exactly those cycles, `beat` held, `out_valid` at cycle 12, same data.
- Result held: `out_ready=0` for 5 cycles in DONE -> `out_valid`/`out_data` stable, `in_ready=0`. Then `out_ready=1` together with `in_valid=1`, `in_data=16'h0001` -> next operation's beats start the following cycle.
- ALU model `ser_in = ser_out + 1` per beat (mod 4), pair `16'h0000` -> `out_data=16'h5555`.
- `reset` asserted at beat 4 -> next cycle IDLE, all outputs at reset values, no `out_valid` ever produced for the aborted operation.
